// File: rtl/cartridge_io_pkg.sv
// Shared types and constants for the MSX cartridge I/O bridge.
package cartridge_io_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } IO_STATE_t;

    // Read data returned to the bus when the device never answers.
    localparam logic [7:0] IO_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/bus_strobe_sync.sv
// Two-flop synchroniser for the asynchronous MSX bus strobes.
// Strobes are active low, so both stages reset to 1 (inactive).
module bus_strobe_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] async_in,
    output logic [2:0] sync_out
);

    logic [2:0] meta_q, meta_d;
    logic [2:0] sync_q, sync_d;

    // Next value of each stage: input into stage 1, stage 1 into stage 2.
    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    // Stage registers; reset to the inactive strobe level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 3'b111;
            sync_q <= 3'b111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/cartridge_io_bridge.sv
// MSX I/O port decoder bridging bus cycles to a simple REQ/ACK device port.
// Holds the Z80 with WAIT_n until the device acknowledges or times out.
module cartridge_io_bridge
    import cartridge_io_pkg::*;
#(
    parameter logic [7:0] IO_BASE_ADDR = 8'h60,
    parameter logic [7:0] IO_MASK      = 8'hF0,
    parameter int         PORT_AW      = 4,
    parameter int         TIMEOUT_CYC  = 255,
    parameter bit         MIRROR       = 1'b0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BUS_IORQ_n,
    input  logic               BUS_RD_n,
    input  logic               BUS_WR_n,
    input  logic [7:0]         BUS_ADDR,
    input  logic [7:0]         BUS_DIN,
    output logic [7:0]         BUS_DOUT,
    output logic               BUS_BUSDIR_n,
    output logic               BUS_WAIT_n,
    output logic               DEV_REQ,
    output logic               DEV_WE,
    output logic [PORT_AW-1:0] DEV_ADDR,
    output logic [7:0]         DEV_WDATA,
    input  logic [7:0]         DEV_RDATA,
    input  logic               DEV_ACK,
    output logic               TIMEOUT_STB
);

    logic [2:0] strobe_s;
    logic       iorq_s, rd_s, wr_s;

    bus_strobe_sync u_sync (
        .clk      (CLK),
        .rst      (RESET),
        .async_in ({BUS_IORQ_n, BUS_RD_n, BUS_WR_n}),
        .sync_out (strobe_s)
    );

    assign {iorq_s, rd_s, wr_s} = strobe_s;

    IO_STATE_t          state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         din_q, din_d;
    logic [7:0]         dout_q, dout_d;
    logic               busdir_n_q, busdir_n_d;
    logic               wait_n_q, wait_n_d;
    logic               dev_req_q, dev_req_d;
    logic               dev_we_q, dev_we_d;
    logic [PORT_AW-1:0] dev_addr_q, dev_addr_d;
    logic [7:0]         dev_wdata_q, dev_wdata_d;
    logic               tstb_q, tstb_d;
    logic               abort_q, abort_d;

    logic strobe_act, addr_ok, is_write, hit, released, expired;

    // Decode from synchronised strobes and the registered address only.
    always_comb begin
        strobe_act = !iorq_s && (!rd_s || !wr_s);
        addr_ok    = (addr_q & IO_MASK) == (IO_BASE_ADDR & IO_MASK);
        is_write   = !wr_s;
        hit        = strobe_act && addr_ok && (!MIRROR || is_write);
        released   = iorq_s || (rd_s && wr_s);
        expired    = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYC);
    end

    // Next-state and output logic; device handshake always completes,
    // the bus is only driven for a read whose cycle is still open.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = BUS_ADDR;
        din_d       = BUS_DIN;
        dout_d      = dout_q;
        busdir_n_d  = busdir_n_q;
        wait_n_d    = wait_n_q;
        dev_req_d   = dev_req_q;
        dev_we_d    = dev_we_q;
        dev_addr_d  = dev_addr_q;
        dev_wdata_d = dev_wdata_q;
        tstb_d      = 1'b0;
        abort_d     = abort_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d     = REQ;
                    cnt_d       = 16'd0;
                    dev_req_d   = 1'b1;
                    wait_n_d    = MIRROR;
                    dev_we_d    = is_write;
                    dev_addr_d  = addr_q[PORT_AW-1:0];
                    dev_wdata_d = din_q;
                    abort_d     = 1'b0;
                end
            end
            REQ: begin
                abort_d = abort_q || released;
                if (DEV_ACK || expired) begin
                    state_d   = HOLD;
                    dev_req_d = 1'b0;
                    wait_n_d  = 1'b1;
                    tstb_d    = !DEV_ACK;
                    if (!dev_we_q && !abort_d && !MIRROR) begin
                        dout_d     = DEV_ACK ? DEV_RDATA : IO_TIMEOUT_DATA;
                        busdir_n_d = 1'b0;
                    end
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HOLD: begin
                if (released) begin
                    state_d    = IDLE;
                    dout_d     = 8'h00;
                    busdir_n_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            addr_q      <= 8'h00;
            din_q       <= 8'h00;
            dout_q      <= 8'h00;
            busdir_n_q  <= 1'b1;
            wait_n_q    <= 1'b1;
            dev_req_q   <= 1'b0;
            dev_we_q    <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= 8'h00;
            tstb_q      <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            dout_q      <= dout_d;
            busdir_n_q  <= busdir_n_d;
            wait_n_q    <= wait_n_d;
            dev_req_q   <= dev_req_d;
            dev_we_q    <= dev_we_d;
            dev_addr_q  <= dev_addr_d;
            dev_wdata_q <= dev_wdata_d;
            tstb_q      <= tstb_d;
            abort_q     <= abort_d;
        end
    end

    assign BUS_DOUT     = dout_q;
    assign BUS_BUSDIR_n = busdir_n_q;
    assign BUS_WAIT_n   = wait_n_q;
    assign DEV_REQ      = dev_req_q;
    assign DEV_WE       = dev_we_q;
    assign DEV_ADDR     = dev_addr_q;
    assign DEV_WDATA    = dev_wdata_q;
    assign TIMEOUT_STB  = tstb_q;

endmodule

// File: tb/tb_cartridge_io_bridge.sv
// Directed bench: table of bus accesses plus hand-written corner sequences.
module tb_cartridge_io_bridge;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       BUS_IORQ_n = 1'b1, BUS_RD_n = 1'b1, BUS_WR_n = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00, BUS_DIN = 8'h00;
    logic [7:0] BUS_DOUT;
    logic       BUS_BUSDIR_n, BUS_WAIT_n, DEV_REQ, DEV_WE, TIMEOUT_STB;
    logic [3:0] DEV_ADDR;
    logic [7:0] DEV_WDATA;
    logic [7:0] DEV_RDATA = 8'h00;
    logic       DEV_ACK = 1'b0;

    logic       m_IORQ_n = 1'b1, m_RD_n = 1'b1, m_WR_n = 1'b1;
    logic [7:0] m_ADDR = 8'h00, m_DIN = 8'h00;
    logic [7:0] m_DOUT;
    logic       m_BUSDIR_n, m_WAIT_n, m_DEV_REQ, m_DEV_WE, m_TSTB;
    logic [3:0] m_DEV_ADDR;
    logic [7:0] m_DEV_WDATA;
    logic       m_ACK = 1'b0;
    logic       m_bad = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    cartridge_io_bridge #(.TIMEOUT_CYC(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .BUS_IORQ_n(BUS_IORQ_n), .BUS_RD_n(BUS_RD_n), .BUS_WR_n(BUS_WR_n),
        .BUS_ADDR(BUS_ADDR), .BUS_DIN(BUS_DIN), .BUS_DOUT(BUS_DOUT),
        .BUS_BUSDIR_n(BUS_BUSDIR_n), .BUS_WAIT_n(BUS_WAIT_n),
        .DEV_REQ(DEV_REQ), .DEV_WE(DEV_WE), .DEV_ADDR(DEV_ADDR),
        .DEV_WDATA(DEV_WDATA), .DEV_RDATA(DEV_RDATA), .DEV_ACK(DEV_ACK),
        .TIMEOUT_STB(TIMEOUT_STB)
    );

    cartridge_io_bridge #(.TIMEOUT_CYC(8), .MIRROR(1'b1)) dut_mir (
        .CLK(CLK), .RESET(RESET),
        .BUS_IORQ_n(m_IORQ_n), .BUS_RD_n(m_RD_n), .BUS_WR_n(m_WR_n),
        .BUS_ADDR(m_ADDR), .BUS_DIN(m_DIN), .BUS_DOUT(m_DOUT),
        .BUS_BUSDIR_n(m_BUSDIR_n), .BUS_WAIT_n(m_WAIT_n),
        .DEV_REQ(m_DEV_REQ), .DEV_WE(m_DEV_WE), .DEV_ADDR(m_DEV_ADDR),
        .DEV_WDATA(m_DEV_WDATA), .DEV_RDATA(8'h99), .DEV_ACK(m_ACK),
        .TIMEOUT_STB(m_TSTB)
    );

    // Mirror bus outputs must never move away from the idle levels.
    always @(negedge CLK)
        if (m_WAIT_n !== 1'b1 || m_BUSDIR_n !== 1'b1 || m_DOUT !== 8'h00)
            m_bad <= 1'b1;

    typedef struct {
        logic [7:0] addr;
        bit         wr;
        logic [7:0] wdata;
        int         ack_dly;   // REQ cycle index carrying ACK, -1 = none
        logic [7:0] rdata;
        bit         exp_req;
        int         exp_cycles;
        bit         exp_to;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        bit seen, stable_ok;
        @(negedge CLK);
        BUS_ADDR = v.addr; BUS_DIN = v.wdata; DEV_RDATA = v.rdata;
        BUS_IORQ_n = 1'b0; BUS_RD_n = v.wr; BUS_WR_n = !v.wr;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (DEV_REQ) seen = 1'b1;
        end
        chk($sformatf("req_seen_%0h", v.addr), seen, v.exp_req);
        if (!v.exp_req) begin
            chk("noreq_bus", {BUS_WAIT_n, BUS_BUSDIR_n, BUS_DOUT}, {1'b1, 1'b1, 8'h00});
        end else begin
            chk("dev_we", DEV_WE, v.wr);
            chk("dev_addr", DEV_ADDR, v.addr[3:0]);
            if (v.wr) chk("dev_wdata", DEV_WDATA, v.wdata);
            k = 0;
            stable_ok = 1'b1;
            while (DEV_REQ && k < 300) begin
                DEV_ACK = (k == v.ack_dly);
                if (BUS_WAIT_n !== 1'b0 || DEV_ADDR !== v.addr[3:0] || DEV_WE !== v.wr)
                    stable_ok = 1'b0;
                @(negedge CLK);
                k++;
            end
            DEV_ACK = 1'b0;
            chk("req_cycles", k, v.exp_cycles);
            chk("req_stable_wait_low", stable_ok, 1'b1);
            chk("wait_released", BUS_WAIT_n, 1'b1);
            chk("timeout_stb", TIMEOUT_STB, v.exp_to);
            chk("busdir_n", BUS_BUSDIR_n, v.wr);
            chk("dout", BUS_DOUT, v.exp_dout);
            if (v.exp_to) begin
                DEV_ACK = 1'b1;
                @(negedge CLK);
                DEV_ACK = 1'b0;
                chk("timeout_stb_one_cycle", TIMEOUT_STB, 1'b0);
                chk("late_ack_req", DEV_REQ, 1'b0);
                chk("late_ack_dout", BUS_DOUT, v.exp_dout);
            end
        end
        BUS_IORQ_n = 1'b1; BUS_RD_n = 1'b1; BUS_WR_n = 1'b1;
        repeat (2) @(negedge CLK);
        chk("hold_dout", BUS_DOUT, v.exp_req ? v.exp_dout : 8'h00);
        @(negedge CLK);
        chk("rel_dout", BUS_DOUT, 8'h00);
        chk("rel_busdir_n", BUS_BUSDIR_n, 1'b1);
        repeat (2) @(negedge CLK);
    endtask

    initial begin : main
        bit seen;
        //          addr   wr  wdata  ack  rdata  req cyc to dout
        vecs[0] = '{8'h65, 1, 8'h3C,  3, 8'h00, 1, 4, 0, 8'h00};
        vecs[1] = '{8'h6A, 0, 8'h00,  0, 8'hA5, 1, 1, 0, 8'hA5};
        vecs[2] = '{8'h63, 0, 8'h00, -1, 8'h77, 1, 8, 1, 8'hFF};
        vecs[3] = '{8'h70, 0, 8'h00,  0, 8'h11, 0, 0, 0, 8'h00};
        vecs[4] = '{8'h5F, 1, 8'h22,  0, 8'h00, 0, 0, 0, 8'h00};
        vecs[5] = '{8'h6F, 0, 8'h00,  7, 8'h5A, 1, 8, 0, 8'h5A};
        vecs[6] = '{8'h60, 1, 8'h81,  1, 8'h00, 1, 2, 0, 8'h00};
        vecs[7] = '{8'h69, 0, 8'h00,  2, 8'h00, 1, 3, 0, 8'h00};

        repeat (3) @(negedge CLK);
        chk("rst_outputs",
            {BUS_DOUT, BUS_BUSDIR_n, BUS_WAIT_n, DEV_REQ, DEV_WE, DEV_ADDR, DEV_WDATA, TIMEOUT_STB},
            {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0});
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Bus aborts during REQ: handshake completes, bus is not driven.
        BUS_ADDR = 8'h62; BUS_IORQ_n = 1'b0; BUS_RD_n = 1'b0; DEV_RDATA = 8'hC3;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (DEV_REQ) seen = 1'b1;
        end
        chk("abort_req_seen", seen, 1'b1);
        BUS_IORQ_n = 1'b1; BUS_RD_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("abort_req_still_high", DEV_REQ, 1'b1);
        DEV_ACK = 1'b1;
        @(negedge CLK);
        DEV_ACK = 1'b0;
        chk("abort_done", {DEV_REQ, BUS_WAIT_n, BUS_BUSDIR_n, BUS_DOUT}, {1'b0, 1'b1, 1'b1, 8'h00});
        @(negedge CLK);
        chk("abort_idle_busdir", BUS_BUSDIR_n, 1'b1);
        repeat (2) @(negedge CLK);

        // Reset in the middle of a write request.
        BUS_ADDR = 8'h64; BUS_DIN = 8'h77; BUS_IORQ_n = 1'b0; BUS_WR_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (DEV_REQ) seen = 1'b1;
        end
        chk("rst_mid_req_seen", {seen, DEV_ADDR, DEV_WDATA}, {1'b1, 4'h4, 8'h77});
        RESET = 1'b1; BUS_IORQ_n = 1'b1; BUS_WR_n = 1'b1;
        @(negedge CLK);
        chk("rst_mid_outputs",
            {BUS_DOUT, BUS_BUSDIR_n, BUS_WAIT_n, DEV_REQ, DEV_WE, DEV_ADDR, DEV_WDATA, TIMEOUT_STB},
            {8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 1'b0});
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        run_vec('{8'h6B, 0, 8'h00, 1, 8'h3E, 1, 2, 0, 8'h3E});

        // Mirror instance: read ignored, write forwarded.
        m_ADDR = 8'h60; m_IORQ_n = 1'b0; m_RD_n = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (m_DEV_REQ) seen = 1'b1;
        end
        chk("mir_read_noreq", seen, 1'b0);
        m_IORQ_n = 1'b1; m_RD_n = 1'b1;
        repeat (4) @(negedge CLK);
        m_ADDR = 8'h61; m_DIN = 8'h12; m_IORQ_n = 1'b0; m_WR_n = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge CLK);
            if (m_DEV_REQ) seen = 1'b1;
        end
        chk("mir_write_req", seen, 1'b1);
        chk("mir_write_fields", {m_DEV_WE, m_DEV_ADDR, m_DEV_WDATA}, {1'b1, 4'h1, 8'h12});
        m_ACK = 1'b1;
        @(negedge CLK);
        m_ACK = 1'b0;
        chk("mir_write_done", {m_DEV_REQ, m_TSTB}, {1'b0, 1'b0});
        m_IORQ_n = 1'b1; m_WR_n = 1'b1;
        repeat (4) @(negedge CLK);
        chk("mir_bus_constant", m_bad, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
